func_ci_sequencer: RTL
======================

# func_ci_sequencer

Multi-cycle Nios II custom-instruction front end for the floating-point function core that evaluates y = 0.5·x + x²·cos((x−128)/128).
- Accepts opcode-tagged requests from the Nios ALU port and launches the core with a single-cycle start pulse.
- Waits for the core's completion flag, then returns the IEEE-754 single result with a one-cycle `done`.
- Also provides last-result readback, a status/counter word, a sticky-error clear and an optional hang watchdog.
- Sits directly upstream of the function core, between the Nios custom-instruction bus and the core's `start`/`data` inputs.

## Interface
Parameters:
- TIMEOUT_CYCLES, 4096: maximum WAIT cycles before the watchdog aborts (used only with the watchdog compiled in).
- CNT_W, 16: width of the evaluation counter.

Ports:
- clk  in  1: the single clock.
- reset  in  1: synchronous, active-high; overrides `clk_en`.
- clk_en  in  1: Nios clock enable; all non-reset register updates are qualified by it.
- start  in  1: request strobe, sampled in IDLE only.
- n  in  2: opcode. 0 = EVAL, 1 = READ_LAST, 2 = STATUS, 3 = CLEAR.
- dataa  in  32: float operand x, used by EVAL only.
- done  out  1: one-cycle completion pulse; reset 0.
- result  out  32: return word, valid while `done`=1 and held afterwards; reset 0.
- core_start  out  1: one-cycle launch pulse to the core; reset 0.
- core_data  out  32: registered operand to the core, held until the next EVAL; reset 0.
- core_result  in  32: core output float.
- core_done  in  1: core completion flag, level; stays high until the core's next start.

## Operation
States are IDLE, LAUNCH, WAIT, FINISH, encoded 0–3.

- **IDLE**, with `start`=1:
  - n=0: latch `dataa` into `core_data`, go to LAUNCH.
  - n=1, 2 or 3: go to FINISH with the reply word selected.
- **LAUNCH**: `core_start`=1 for exactly this cycle, then go to WAIT. Clear the watchdog counter.
- **WAIT**:
  - `core_done` is ignored on the first WAIT cycle, because the flag can still be high from the previous evaluation.
  - From the second WAIT cycle on, `core_done`=1 captures `core_result` into the last-result register, increments `eval_count`, and goes to FINISH.
- **FINISH**: `done`=1 and `result` is driven with the reply, then go to IDLE.

Reply words:
- EVAL: the captured core result.
- READ_LAST: the last-result register. After reset it is 0x00000000.
- STATUS: [31] timeout_err, [30] proto_err, [29:18] 0, [17:16] state at sample time, [15:0] eval_count.
- CLEAR: 0x00000000. The sticky errors and `eval_count` become 0 in the FINISH cycle. The last-result register is preserved.

Other rules:
- `start`=1 in any state other than IDLE is ignored, and sets proto_err (sticky).
- `eval_count` wraps from 0xFFFF to 0x0000.
- `clk_en`=0 freezes all state, counters and outputs. A `done` pulse therefore lasts one enabled cycle.
- When `reset` is asserted mid-operation:
  - The block returns to IDLE, all outputs go to 0 and all registers are cleared.
  - The core is not aborted; its stale `core_done` is masked by the first-WAIT-cycle rule.

## Timing
- READ_LAST, STATUS, CLEAR: `start` at cycle T, `done` at T+1.
- EVAL:
  - `start` at T, `core_start` at T+1.
  - WAIT starts at T+2; the earliest accepted `core_done` is at T+3.
  - `done` comes one cycle after the accepted `core_done`, so the minimum latency is 4.
- `core_data` is stable from T+1 until the next EVAL is accepted.
- Back-to-back operation: a new `start` may be presented in the cycle after `done`.

## Configuration
- `FUNC_CI_WATCHDOG_EN` defined:
  - The counter runs in WAIT.
  - When it reaches TIMEOUT_CYCLES without an accepted `core_done`, the block goes to FINISH with `result`=0x7FC00000 (quiet NaN).
  - It sets timeout_err (sticky); `eval_count` and the last-result register are unchanged.
- Not defined: no counter logic. WAIT waits indefinitely, and STATUS[31] reads 0.

## Structure
- Shared package `func_ci_pkg` holds:
  - the opcode constants OP_EVAL/OP_READ_LAST/OP_STATUS/OP_CLEAR;
  - the state encoding;
  - the STATUS bit positions;
  - FLOAT_QNAN = 0x7FC00000.
- One sub-module, `ci_watchdog`, holds the counter: clear, run and expiry pulse, parameterised by TIMEOUT_CYCLES. It is instantiated only under `FUNC_CI_WATCHDOG_EN`.

## Test plan
- EVAL, dataa=0x43000000 (128.0), core model answers 0x46808000 (16448.0) with core_done 5 cycles after core_start → one core_start pulse, core_data=0x43000000, done once with result=0x46808000, STATUS[15:0]=1.
- EVAL while the core model holds core_done=1 from the previous op → the stale flag is not accepted; done appears only after a fresh core_done, minimum latency 4.
- READ_LAST after reset → done at T+1, result=0; after the first test → 0x46808000.
- start re-asserted during WAIT → ignored; STATUS[30]=1; a following CLEAR returns 0 and STATUS then reads 0x00000000.
- Watchdog enabled, TIMEOUT_CYCLES=8, core never completes → done with result=0x7FC00000, STATUS[31]=1, eval_count unchanged.
- reset in WAIT, and clk_en=0 for 3 cycles in LAUNCH → reset gives outputs 0 and IDLE next cycle; the clk_en stall holds core_start=1 and delays done by exactly 3 cycles.

Source files
------------

// File: rtl/func_ci_pkg.sv
// ============================================================================
// Module      : func_ci_pkg
// Description : Shared opcodes, state encoding, STATUS word layout and float
//               constants for the func_ci_sequencer custom-instruction front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package func_ci_pkg;

  // Custom-instruction opcodes carried on the n field
  localparam logic [1:0] OP_EVAL      = 2'd0;
  localparam logic [1:0] OP_READ_LAST = 2'd1;
  localparam logic [1:0] OP_STATUS    = 2'd2;
  localparam logic [1:0] OP_CLEAR     = 2'd3;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // STATUS word bit positions
  localparam int STATUS_TIMEOUT_BIT = 31;
  localparam int STATUS_PROTO_BIT   = 30;
  localparam int STATUS_STATE_LSB   = 16;
  localparam int STATUS_COUNT_LSB   = 0;

  // Quiet NaN returned when an evaluation is abandoned
  localparam logic [31:0] FLOAT_QNAN = 32'h7FC0_0000;

  // Assemble the STATUS reply word; unlisted bits read as zero
  function automatic logic [31:0] pack_status(
    input logic        timeout_err,
    input logic        proto_err,
    input logic [1:0]  state,
    input logic [15:0] count
  );
    logic [31:0] w;
    w = 32'h0;
    w[STATUS_TIMEOUT_BIT]                     = timeout_err;
    w[STATUS_PROTO_BIT]                       = proto_err;
    w[STATUS_STATE_LSB +: 2]                  = state;
    w[STATUS_COUNT_LSB +: 16]                 = count;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ci_watchdog.sv
// ============================================================================
// Module      : ci_watchdog
// Description : Cycle counter that flags an evaluation which has run for
//               TIMEOUT_CYCLES wait cycles without completing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ci_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Expire on the cycle that would be the TIMEOUT_CYCLES-th running cycle
  assign o_expire = i_run && (cnt_q == C_LAST);

  // Next count: clear wins, otherwise advance while running
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_run && !o_expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/func_ci_sequencer.sv
// ============================================================================
// Module      : func_ci_sequencer
// Description : Multi-cycle Nios II custom-instruction front end for the
//               floating-point function core. Launches the core on EVAL,
//               returns its result, and serves READ_LAST / STATUS / CLEAR.
//               Optional hang watchdog: define FUNC_CI_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module func_ci_sequencer
  import func_ci_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        core_start,
  output logic [31:0] core_data,
  input  logic [31:0] core_result,
  input  logic        core_done
);

  state_e             state_q, state_d;
  logic [31:0]        core_data_q, core_data_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        last_q, last_d;
  logic [CNT_W-1:0]   eval_count_q, eval_count_d;
  logic               proto_err_q, proto_err_d;
  logic               timeout_err_q, timeout_err_d;
  logic               first_wait_q, first_wait_d;
  logic               expire;
  logic [31:0]        status_word;

`ifdef FUNC_CI_WATCHDOG_EN
  // Watchdog is cleared on launch and runs only during enabled WAIT cycles
  ci_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (clk_en && (state_q == ST_LAUNCH)),
    .i_run    (clk_en && (state_q == ST_WAIT)),
    .o_expire (expire)
  );
`else
  // Without the watchdog an evaluation waits for the core indefinitely
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
  assign expire           = 1'b0;
`endif

  assign status_word = pack_status(timeout_err_q, proto_err_q, state_q,
                                   16'(eval_count_q));

  // Outputs are pure functions of registered state so reset forces them low
  assign done       = (state_q == ST_FINISH);
  assign core_start = (state_q == ST_LAUNCH);
  assign result     = result_q;
  assign core_data  = core_data_q;

  // Next-state and datapath updates; everything holds while clk_en is low
  always_comb begin
    state_d        = state_q;
    core_data_d    = core_data_q;
    result_d       = result_q;
    last_d         = last_q;
    eval_count_d   = eval_count_q;
    proto_err_d    = proto_err_q;
    timeout_err_d  = timeout_err_q;
    first_wait_d   = first_wait_q;

    if (clk_en) begin
      // The core's done flag may still be high from the previous run, so
      // the first WAIT cycle after a launch never accepts it.
      first_wait_d = (state_q == ST_LAUNCH);

      if (start && (state_q != ST_IDLE)) begin
        proto_err_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            case (n)
              OP_EVAL: begin
                core_data_d = dataa;
                state_d     = ST_LAUNCH;
              end
              OP_READ_LAST: begin
                result_d = last_q;
                state_d  = ST_FINISH;
              end
              OP_STATUS: begin
                result_d = status_word;
                state_d  = ST_FINISH;
              end
              default: begin
                result_d      = 32'h0;
                proto_err_d   = 1'b0;
                timeout_err_d = 1'b0;
                eval_count_d  = '0;
                state_d       = ST_FINISH;
              end
            endcase
          end
        end
        ST_LAUNCH: begin
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done && !first_wait_q) begin
            last_d       = core_result;
            result_d     = core_result;
            eval_count_d = eval_count_q + 1'b1;
            state_d      = ST_FINISH;
          end else if (expire) begin
            result_d      = FLOAT_QNAN;
            timeout_err_d = 1'b1;
            state_d       = ST_FINISH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset overrides the clock enable
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      core_data_q   <= 32'h0;
      result_q      <= 32'h0;
      last_q        <= 32'h0;
      eval_count_q  <= '0;
      proto_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      first_wait_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      core_data_q   <= core_data_d;
      result_q      <= result_d;
      last_q        <= last_d;
      eval_count_q  <= eval_count_d;
      proto_err_q   <= proto_err_d;
      timeout_err_q <= timeout_err_d;
      first_wait_q  <= first_wait_d;
    end
  end

endmodule

`default_nettype wire
